// File: rtl/bsg_alu_acc_driver.sv
// bsg_alu_acc_driver
//   Command-side initiator for an external 4-op combinational ALU
//   (AND/XOR/NAND/ADD). Commands arrive over valid/ready. Each one is
//   issued to the ALU from registers for one cycle. The result is then
//   captured into the accumulator and returned over valid/yumi.
//
//   Optional feature macro: BSG_ALU_ACC_DRIVER_CHECK_EN
//     When defined, an internal reference recomputes op(acc, operand)
//     during ISSUE and sets the sticky err_o flag on any non-load
//     mismatch. When undefined, err_o is tied to 0.
//
//   Handshakes:
//     - A command transfers on a rising edge where v_i & ready_o.
//     - A response transfers on a rising edge where v_o & yumi_i.
//     - v_i while ready_o=0 is ignored. yumi_i while v_o=0 is ignored.
//     - In RESP, ready_o follows yumi_i, so a response can be retired
//       and a new command accepted on the same edge.
//
//   state_o exposes the FSM state for debug:
//     0 = IDLE, 1 = ISSUE, 2 = RESP.
module bsg_alu_acc_driver #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic               load_i,
   input  logic [1:0]         op_i,
   input  logic [width_p-1:0] data_i,
   output logic [1:0]         alu_control_o,
   output logic [width_p-1:0] alu_a_o,
   output logic [width_p-1:0] alu_b_o,
   input  logic [width_p-1:0] alu_res_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic [width_p-1:0] acc_o,
   output logic               err_o,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e             state_r;
   logic               load_r;
   logic [1:0]         ctl_r;
   logic [width_p-1:0] b_r;
   logic [width_p-1:0] acc_r;
   logic [width_p-1:0] data_r;
   logic [width_p-1:0] next_acc;

   // Loads bypass the ALU and take the latched operand directly.
   assign next_acc = load_r ? b_r : alu_res_i;

   // Ready when idle, or in RESP exactly on the cycle the response is consumed.
   assign ready_o = (state_r == IDLE) | ((state_r == RESP) & yumi_i);

   assign v_o           = (state_r == RESP);
   assign alu_control_o = ctl_r;
   assign alu_a_o       = acc_r;
   assign alu_b_o       = b_r;
   assign acc_o         = acc_r;
   assign data_o        = data_r;
   assign state_o       = state_r;

   // Command FSM.
   // ALU drive registers change only on accept edges.
   // The accumulator and response change only at the end of ISSUE.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         load_r  <= 1'b0;
         ctl_r   <= 2'b00;
         b_r     <= '0;
         acc_r   <= '0;
         data_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (v_i) begin
                  load_r  <= load_i;
                  ctl_r   <= op_i;
                  b_r     <= data_i;
                  state_r <= ISSUE;
               end
            end
            ISSUE: begin
               acc_r   <= next_acc;
               data_r  <= next_acc;
               state_r <= RESP;
            end
            RESP: begin
               if (yumi_i) begin
                  if (v_i) begin
                     load_r  <= load_i;
                     ctl_r   <= op_i;
                     b_r     <= data_i;
                     state_r <= ISSUE;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

`ifdef BSG_ALU_ACC_DRIVER_CHECK_EN
   logic [width_p-1:0] exp_res;
   logic               err_r;

   // Reference model of the external ALU, evaluated on the registered drive values.
   always_comb begin
      exp_res = '0;
      case (ctl_r)
         2'b00:   exp_res = acc_r & b_r;
         2'b01:   exp_res = acc_r ^ b_r;
         2'b10:   exp_res = ~(acc_r & b_r);
         default: exp_res = acc_r + b_r;
      endcase
   end

   // Sticky mismatch flag; only ALU ops are checked, loads ignore the ALU.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r <= 1'b0;
      end else if ((state_r == ISSUE) && !load_r && (alu_res_i != exp_res)) begin
         err_r <= 1'b1;
      end
   end

   assign err_o = err_r;
`else
   assign err_o = 1'b0;
`endif

endmodule
